key_schedule_iter: RTL and testbench

KEY_SCHEDULE_ITER -- requirements
Module: key_schedule_iter

---
 rtl/key_schedule_iter.sv | 175 +++++++++++++++++
 tb/tb_key_schedule_iter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/key_schedule_iter.sv
// Iterative AES-128 key expansion: one round key per clock over ten EXPAND cycles,
// all eleven round keys held in registers for the decryption pipeline.
module key_schedule_iter (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] key,
    output logic         busy,
    output logic         keys_valid,
    output logic [127:0] cipher_key_out,
    output logic [127:0] round1_key,
    output logic [127:0] round2_key,
    output logic [127:0] round3_key,
    output logic [127:0] round4_key,
    output logic [127:0] round5_key,
    output logic [127:0] round6_key,
    output logic [127:0] round7_key,
    output logic [127:0] round8_key,
    output logic [127:0] round9_key,
    output logic [127:0] round10_key
);

    localparam int unsigned KEY_W  = 128;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned ROUNDS = 10;

    localparam logic [BYTE_W-1:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_t;

    function automatic logic [WORD_W-1:0] sub_word(input logic [WORD_W-1:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [BYTE_W-1:0] rcon(input logic [CNT_W-1:0] n);
        logic [BYTE_W-1:0] rc;
        case (n)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // One AES-128 expansion step: four new words from the previous round key.
    function automatic logic [KEY_W-1:0] expand_step(input logic [KEY_W-1:0] prev,
                                                     input logic [BYTE_W-1:0] rc);
        logic [WORD_W-1:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
        {w0, w1, w2, w3} = prev;
        t  = sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h0};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              valid_d;
    logic              busy_d;
    logic              cap_key;
    logic              wr_rk;
    logic [KEY_W-1:0]  rk_q [0:ROUNDS];
    logic [KEY_W-1:0]  prev_key;
    logic [KEY_W-1:0]  next_key;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            keys_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            keys_valid <= valid_d;
            busy       <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = keys_valid;
        cap_key = 1'b0;
        wr_rk   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = EXPAND;
                    cnt_d   = CNT_W'(1);
                    valid_d = 1'b0;
                    cap_key = 1'b1;
                end
            end
            EXPAND: begin
                wr_rk = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ROUNDS)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == EXPAND);
    end

    // Round n derives from round n-1; slot 0 is the captured cipher key.
    always_comb begin
        prev_key = rk_q[0];
        for (int unsigned i = 1; i < ROUNDS; i++) begin
            if (cnt_q == CNT_W'(i + 1)) prev_key = rk_q[i];
        end
        next_key = expand_step(prev_key, rcon(cnt_q));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i <= ROUNDS; i++) rk_q[i] <= '0;
        end else begin
            if (cap_key) rk_q[0] <= key;
            if (wr_rk) begin
                for (int unsigned i = 1; i <= ROUNDS; i++) begin
                    if (cnt_q == CNT_W'(i)) rk_q[i] <= next_key;
                end
            end
        end
    end

    assign cipher_key_out = rk_q[0];
    assign round1_key     = rk_q[1];
    assign round2_key     = rk_q[2];
    assign round3_key     = rk_q[3];
    assign round4_key     = rk_q[4];
    assign round5_key     = rk_q[5];
    assign round6_key     = rk_q[6];
    assign round7_key     = rk_q[7];
    assign round8_key     = rk_q[8];
    assign round9_key     = rk_q[9];
    assign round10_key    = rk_q[10];

endmodule

// File: tb/tb_key_schedule_iter.sv
// Directed bench for key_schedule_iter: FIPS-197 and all-zero key vectors, ignored
// start, restart, async abort and back-to-back expansion, checked via a scoreboard queue.
module tb_key_schedule_iter;

    typedef struct packed {
        logic [127:0] k0;
        logic [127:0] r1;
        logic [127:0] r10;
        logic         full;
    } exp_t;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ZERO_KEY = 128'h0;
    localparam logic [127:0] FIPS_RK [1:10] = '{
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };
    localparam exp_t EXP_FIPS = '{k0: FIPS_KEY, r1: 128'ha0fafe1788542cb123a339392a6c7605,
                                  r10: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, full: 1'b1};
    localparam exp_t EXP_ZERO = '{k0: ZERO_KEY, r1: 128'h62636363626363636263636362636363,
                                  r10: 128'hb4ef5bcb3e92e21123e951cf6f8f188e, full: 1'b0};

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] key;
    logic         busy;
    logic         keys_valid;
    logic [127:0] cipher_key_out;
    logic [127:0] round1_key, round2_key, round3_key, round4_key, round5_key;
    logic [127:0] round6_key, round7_key, round8_key, round9_key, round10_key;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    key_schedule_iter dut (
        .clk(clk), .reset(reset), .start(start), .key(key),
        .busy(busy), .keys_valid(keys_valid), .cipher_key_out(cipher_key_out),
        .round1_key(round1_key), .round2_key(round2_key), .round3_key(round3_key),
        .round4_key(round4_key), .round5_key(round5_key), .round6_key(round6_key),
        .round7_key(round7_key), .round8_key(round8_key), .round9_key(round9_key),
        .round10_key(round10_key)
    );

    function automatic logic [127:0] dut_rk(input int i);
        case (i)
            1:       return round1_key;
            2:       return round2_key;
            3:       return round3_key;
            4:       return round4_key;
            5:       return round5_key;
            6:       return round6_key;
            7:       return round7_key;
            8:       return round8_key;
            9:       return round9_key;
            10:      return round10_key;
            default: return '0;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pop the oldest expected schedule and compare it against the DUT outputs.
    task automatic score(input string tag);
        exp_t e;
        checks++;
        assert (sb_q.size() > 0) else begin
            failures++;
            $error("FAIL %s_sb_empty observed=0 expected=1", tag);
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({tag, "_valid"}, 128'(keys_valid), 128'(1));
            chk({tag, "_k0"}, cipher_key_out, e.k0);
            chk({tag, "_r1"}, round1_key, e.r1);
            chk({tag, "_r10"}, round10_key, e.r10);
            if (e.full) begin
                for (int i = 2; i <= 9; i++) chk($sformatf("%s_r%0d", tag, i), dut_rk(i), FIPS_RK[i]);
            end
        end
    endtask

    // Called just after the accepting edge; the accepting edge counts as edge 1.
    // pulse_at > 0 drives a stray start with a zero key at that edge count.
    task automatic run_to_valid(input string tag, input int pulse_at);
        int edges    = 1;
        int busy_cyc = int'(busy);
        while (!keys_valid && edges < 30) begin
            if (pulse_at > 0) begin
                start = (edges == pulse_at);
                if (edges == pulse_at) key = ZERO_KEY;
            end
            tick();
            edges++;
            if (busy) busy_cyc++;
        end
        if (pulse_at > 0) start = 1'b0;
        chk({tag, "_latency"}, 128'(edges), 128'(11));
        chk({tag, "_busy_cycles"}, 128'(busy_cyc), 128'(10));
        score(tag);
    endtask

    task automatic accept(input string tag, input logic [127:0] k, input exp_t e);
        start = 1'b1;
        key   = k;
        sb_q.push_back(e);
        tick();
        start = 1'b0;
        key   = {$urandom, $urandom, $urandom, $urandom};
        chk({tag, "_acc_busy"}, 128'(busy), 128'(1));
        chk({tag, "_acc_valid"}, 128'(keys_valid), 128'(0));
        chk({tag, "_acc_k0"}, cipher_key_out, k);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        key   = '0;
        tick();
        tick();
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_valid", 128'(keys_valid), 128'(0));
        chk("rst_k0", cipher_key_out, '0);
        chk("rst_r1", round1_key, '0);
        chk("rst_r10", round10_key, '0);
        reset = 1'b1;

        accept("fips", FIPS_KEY, EXP_FIPS);
        run_to_valid("fips", 0);

        for (int i = 0; i < 5; i++) tick();
        chk("hold_valid", 128'(keys_valid), 128'(1));
        chk("hold_busy", 128'(busy), 128'(0));
        chk("hold_r10", round10_key, FIPS_RK[10]);

        accept("zero_restart", ZERO_KEY, EXP_ZERO);
        run_to_valid("zero_restart", 0);

        accept("ignore", FIPS_KEY, EXP_FIPS);
        run_to_valid("ignore", 4);

        accept("abort", ZERO_KEY, EXP_ZERO);
        for (int i = 0; i < 5; i++) tick();
        #2;
        reset = 1'b0;
        #1;
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_valid", 128'(keys_valid), 128'(0));
        chk("abort_k0", cipher_key_out, '0);
        chk("abort_r1", round1_key, '0);
        chk("abort_r5", round5_key, '0);
        void'(sb_q.pop_back());
        #2;
        reset = 1'b1;
        accept("post_reset", FIPS_KEY, EXP_FIPS);
        run_to_valid("post_reset", 0);

        // Start held high: the FIPS accept is followed 11 edges later by the zero-key accept.
        start = 1'b1;
        key   = FIPS_KEY;
        sb_q.push_back(EXP_FIPS);
        tick();
        key = ZERO_KEY;
        sb_q.push_back(EXP_ZERO);
        chk("b2b_acc_busy", 128'(busy), 128'(1));
        run_to_valid("b2b_first", 0);
        tick();
        chk("b2b_valid_pulse", 128'(keys_valid), 128'(0));
        chk("b2b_reacc_busy", 128'(busy), 128'(1));
        chk("b2b_reacc_k0", cipher_key_out, ZERO_KEY);
        run_to_valid("b2b_second", 0);
        start = 1'b0;
        tick();
        chk("b2b_sb_drained", 128'(sb_q.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
